cmd_tx: RTL and testbench
=========================

CMD_TX -- requirements
Module: cmd_tx

Interface
REQ-001 Parameter BAUD_DIV, default 2604, gives clk cycles per serial bit (19200 baud at 50 MHz); legal range is 2 to 65535.
REQ-002 Port clk, input, 1, is the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1, is the reset: synchronous, active-high.
REQ-004 Port send_go, input, 1, requests a GO command to dest_id; it is sampled only while idle.
REQ-005 Port send_stop, input, 1, requests a STOP command; it is sampled only while idle.
REQ-006 Port dest_id, input, 6, is the destination station ID for GO.
REQ-007 Port TX, output, 1, is the UART serial line and is high when idle.
REQ-008 Port busy, output, 1, is high from request accept until the end of the stop bit.
REQ-009 Port cmd_sent, output, 1, is a one-cycle pulse that marks frame completion.
REQ-010 Port last_cmd, output, 8, is the most recently accepted command byte.

Function
REQ-011 GO byte SHALL be {2'b01, dest_id}; STOP byte SHALL be 8'h00.
REQ-012 The request decode SHALL act as follows:
- send_go and send_stop high in the same idle cycle: STOP wins.
- Neither high: no action.
REQ-013 A request SHALL be accepted only in IDLE; requests while busy is high are ignored, not queued.
REQ-014 On accept, the byte SHALL be latched into the shift register and last_cmd. Later changes to dest_id SHALL not affect the frame in flight.
REQ-015 The FSM SHALL have states IDLE, START, DATA and STOP.
- IDLE->START on accept.
- START->DATA after BAUD_DIV cycles.
- DATA->STOP after 8 bits of BAUD_DIV cycles each.
- STOP->IDLE after BAUD_DIV cycles.
REQ-016 TX SHALL drive 0 for START, the data bits LSB first for DATA, and 1 for STOP and IDLE.
REQ-017 Latency: TX SHALL fall on the first clk edge after the accept cycle; the frame SHALL last exactly 10*BAUD_DIV cycles.
REQ-018 The baud counter SHALL be 16 bits, count up from 0, and wrap to 0 at BAUD_DIV-1. It SHALL reset to 0 on every state change.
REQ-019 The bit counter SHALL be 3 bits; DATA ends when it wraps from 7 after a full bit period.
REQ-020 Handshake at frame end:
- cmd_sent SHALL be high in the first IDLE cycle after STOP, with busy low in that same cycle.
- A request in that cycle SHALL be accepted, so frames run back-to-back with zero idle bits.
REQ-021 busy SHALL be high in every non-IDLE state and low in IDLE.

Reset
REQ-022 rst high at a clock edge SHALL force state IDLE, TX=1, busy=0, cmd_sent=0, last_cmd=8'h00 and both counters to 0.
REQ-023 A reset mid-frame SHALL abort the frame: TX goes high at that edge, and no cmd_sent is pulsed for the aborted frame.
REQ-024 Requests held high during reset SHALL be ignored. They SHALL be accepted on the first cycle after rst falls if still high.

Structure
REQ-025 Package cmd_pkg SHALL hold:
- opcode constants OP_GO=2'b01 and OP_STOP=2'b00;
- the tx_state_t enum;
- the command-byte width constant of 8.
REQ-026 The serializer SHALL be a sub-module uart_tx (ports: clk, rst, trmt, tx_data[7:0], TX, tx_done, busy).
REQ-027 cmd_tx SHALL contain only the request arbitration, the command encoding and last_cmd, and SHALL instantiate uart_tx.

Verification (BAUD_DIV=4)
REQ-028 Basic GO: dest_id=6'h35 with a one-cycle send_go ->
- last_cmd=8'h75;
- TX bits 0,1,0,1,0,1,1,1,0,1, each 4 cycles;
- cmd_sent pulses 40 cycles after accept.
REQ-029 Arbitration: send_go and send_stop high in the same idle cycle -> last_cmd=8'h00 and the frame carries 8'h00.
REQ-030 Busy rejection: send_go with dest_id=6'h03 at cycle 12 of a frame in flight -> ignored; last_cmd is unchanged and only one cmd_sent occurs.
REQ-031 Back-to-back: send_stop asserted in the cmd_sent cycle -> TX falls on the next edge, and the second frame starts with no idle bit.
REQ-032 Reset mid-frame: rst high at cycle 20 of a frame ->
- TX=1 and busy=0 at that edge;
- no cmd_sent;
- last_cmd=8'h00.
REQ-033 Late dest_id change: dest_id changes to 6'h0C one cycle after accept -> the frame still carries 8'h75.

Source files
------------

// File: rtl/cmd_pkg.sv
// Shared definitions for the command transmitter: opcodes, FSM states and
// the command-byte encoder used by cmd_tx.
package cmd_pkg;

  localparam int CMD_W = 8;

  localparam logic [1:0] OP_GO   = 2'b01;
  localparam logic [1:0] OP_STOP = 2'b00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  // Build the command byte; STOP carries no station ID.
  function automatic logic [CMD_W-1:0] encode_cmd(input logic is_stop,
                                                  input logic [5:0] id);
    logic [CMD_W-1:0] byte_v;
    if (is_stop) begin
      byte_v = {OP_STOP, 6'd0};
    end else begin
      byte_v = {OP_GO, id};
    end
    return byte_v;
  endfunction

endpackage

// File: rtl/cmd_tx_uart_tx.sv
// 8N1 UART serializer. A byte offered with trmt while idle is latched and
// shifted out LSB first; tx_done pulses in the first idle cycle after the
// stop bit. All outputs are registered.
module uart_tx
  import cmd_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       TX,
  output logic       tx_done,
  output logic       busy
);

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

  tx_state_t   state_r;
  logic [15:0] baud_cnt_r;
  logic [2:0]  bit_cnt_r;
  logic [7:0]  shift_r;
  logic        tx_r;
  logic        done_r;
  logic        busy_r;
  logic        baud_end_s;

  // Last cycle of the current bit period.
  always_comb begin
    baud_end_s = (baud_cnt_r == BAUD_LAST);
  end

  // Frame sequencer: state, counters, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      baud_cnt_r <= 16'd0;
      bit_cnt_r  <= 3'd0;
      shift_r    <= 8'h00;
      tx_r       <= 1'b1;
      done_r     <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          baud_cnt_r <= 16'd0;
          bit_cnt_r  <= 3'd0;
          if (trmt) begin
            shift_r <= tx_data;
            state_r <= START;
            tx_r    <= 1'b0;
            busy_r  <= 1'b1;
          end else begin
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
          end
        end
        START: begin
          if (baud_end_s) begin
            state_r    <= DATA;
            baud_cnt_r <= 16'd0;
            tx_r       <= shift_r[0];
          end else begin
            baud_cnt_r <= baud_cnt_r + 16'd1;
          end
        end
        DATA: begin
          if (baud_end_s) begin
            baud_cnt_r <= 16'd0;
            // Wraps 7 -> 0 on the last data bit.
            bit_cnt_r  <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              state_r <= STOP;
              tx_r    <= 1'b1;
            end else begin
              shift_r <= {1'b0, shift_r[7:1]};
              tx_r    <= shift_r[1];
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + 16'd1;
          end
        end
        STOP: begin
          if (baud_end_s) begin
            state_r    <= IDLE;
            baud_cnt_r <= 16'd0;
            done_r     <= 1'b1;
            busy_r     <= 1'b0;
            tx_r       <= 1'b1;
          end else begin
            baud_cnt_r <= baud_cnt_r + 16'd1;
          end
        end
        default: begin
          state_r    <= IDLE;
          baud_cnt_r <= 16'd0;
          bit_cnt_r  <= 3'd0;
          tx_r       <= 1'b1;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

  assign TX      = tx_r;
  assign tx_done = done_r;
  assign busy    = busy_r;

endmodule

// File: rtl/cmd_tx.sv
// Command transmitter: arbitrates GO/STOP requests while the serializer is
// idle, encodes the command byte, remembers the last accepted command and
// hands the byte to uart_tx.
module cmd_tx
  import cmd_pkg::*;
#(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send_go,
  input  logic       send_stop,
  input  logic [5:0] dest_id,
  output logic       TX,
  output logic       busy,
  output logic       cmd_sent,
  output logic [7:0] last_cmd
);

  logic             trmt_s;
  logic [CMD_W-1:0] cmd_byte_s;
  logic [CMD_W-1:0] last_cmd_r;

  // Accept only while the serializer is idle; STOP wins a simultaneous GO.
  always_comb begin
    trmt_s     = (send_go | send_stop) & ~busy;
    cmd_byte_s = encode_cmd(send_stop, dest_id);
  end

  // Remember the command byte captured at accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_cmd_r <= 8'h00;
    end else if (trmt_s) begin
      last_cmd_r <= cmd_byte_s;
    end else begin
      last_cmd_r <= last_cmd_r;
    end
  end

  uart_tx #(
    .BAUD_DIV (BAUD_DIV)
  ) u_uart_tx (
    .clk     (clk),
    .rst     (rst),
    .trmt    (trmt_s),
    .tx_data (cmd_byte_s),
    .TX      (TX),
    .tx_done (cmd_sent),
    .busy    (busy)
  );

  assign last_cmd = last_cmd_r;

endmodule

// File: tb/tb_cmd_tx.sv
// Directed bench for cmd_tx with BAUD_DIV=4. Expected command bytes go into
// a scoreboard queue when a request is driven and are popped when the frame
// is observed on TX.
module tb_cmd_tx;

  localparam int BD = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       send_go;
  logic       send_stop;
  logic [5:0] dest_id;
  logic       TX;
  logic       busy;
  logic       cmd_sent;
  logic [7:0] last_cmd;

  int         tests  = 0;
  int         failed = 0;
  logic [7:0] sb[$];
  logic [7:0] discard;

  cmd_tx #(.BAUD_DIV(BD)) dut (
    .clk       (clk),
    .rst       (rst),
    .send_go   (send_go),
    .send_stop (send_stop),
    .dest_id   (dest_id),
    .TX        (TX),
    .busy      (busy),
    .cmd_sent  (cmd_sent),
    .last_cmd  (last_cmd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Drive a one-cycle request, record the expected byte, check last_cmd.
  task automatic request(input logic go, input logic stop, input logic [5:0] id);
    logic [7:0] exp_b;
    send_go   = go;
    send_stop = stop;
    dest_id   = id;
    exp_b     = stop ? 8'h00 : {2'b01, id};
    sb.push_back(exp_b);
    step();
    send_go   = 1'b0;
    send_stop = 1'b0;
    chk("last_cmd_accept", last_cmd, exp_b);
  endtask

  // Called at the first negedge after the accept edge; checks 10*BD cycles
  // of TX/busy, then cmd_sent with busy low. inj_kind 1: GO with id 03 at
  // inj_cycle for one cycle; inj_kind 2: dest_id changes to 0C at inj_cycle.
  task automatic frame_check(input int inj_cycle, input int inj_kind);
    logic [7:0] exp_b;
    logic       exp_tx;
    int         bitn;
    tests++;
    assert (sb.size() != 0) else begin
      failed++;
      $error("FAIL sb_empty: observed=0 expected=1 entries");
    end
    exp_b = (sb.size() != 0) ? sb.pop_front() : 8'h00;
    for (int n = 0; n < 10 * BD; n++) begin
      bitn = n / BD;
      if (bitn == 0) begin
        exp_tx = 1'b0;
      end else if (bitn == 9) begin
        exp_tx = 1'b1;
      end else begin
        exp_tx = exp_b[bitn-1];
      end
      chk($sformatf("tx_n%0d_byte%0h", n, exp_b), {7'd0, TX}, {7'd0, exp_tx});
      chk($sformatf("busy_sent_n%0d", n), {6'd0, busy, cmd_sent}, 8'd2);
      if (n == inj_cycle) begin
        case (inj_kind)
          1: begin send_go = 1'b1; dest_id = 6'h03; end
          2: dest_id = 6'h0C;
          default: ;
        endcase
      end
      if ((n == inj_cycle + 1) && (inj_kind == 1)) send_go = 1'b0;
      step();
    end
    chk("cmd_sent_end", {6'd0, busy, cmd_sent}, 8'd1);
  endtask

  initial begin
    rst       = 1'b1;
    send_go   = 1'b1;
    send_stop = 1'b0;
    dest_id   = 6'h35;

    // Reset state with a request held high: it must be ignored.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_tx", {7'd0, TX}, 8'd1);
      chk("rst_busy_sent", {6'd0, busy, cmd_sent}, 8'd0);
      chk("rst_last_cmd", last_cmd, 8'h00);
    end

    // Held request accepted on the first cycle after reset falls.
    rst = 1'b0;
    sb.push_back(8'h75);
    step();
    send_go = 1'b0;
    chk("post_rst_accept", last_cmd, 8'h75);
    frame_check(-1, 0);
    step();

    // Basic GO to 0x35.
    request(1'b1, 1'b0, 6'h35);
    frame_check(-1, 0);
    step();
    chk("idle_tx", {7'd0, TX}, 8'd1);

    // Arbitration: STOP wins over GO.
    request(1'b1, 1'b1, 6'h35);
    frame_check(-1, 0);
    step();

    // Busy rejection: GO to 0x03 at cycle 12 is ignored.
    request(1'b1, 1'b0, 6'h35);
    frame_check(12, 1);
    chk("busy_rej_last_cmd", last_cmd, 8'h75);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("busy_rej_no_2nd", {6'd0, busy, cmd_sent}, 8'd0);
    end
    dest_id = 6'h35;

    // Back-to-back: STOP requested in the cmd_sent cycle.
    request(1'b1, 1'b0, 6'h35);
    frame_check(-1, 0);
    request(1'b0, 1'b1, 6'h35);
    frame_check(-1, 0);
    step();

    // Late dest_id change after accept does not affect the frame.
    request(1'b1, 1'b0, 6'h35);
    frame_check(0, 2);
    chk("late_dest_last_cmd", last_cmd, 8'h75);
    dest_id = 6'h35;
    step();

    // Reset at cycle 20 of a frame aborts it.
    request(1'b1, 1'b0, 6'h35);
    repeat (19) step();
    rst = 1'b1;
    step();
    chk("abort_tx", {7'd0, TX}, 8'd1);
    chk("abort_busy_sent", {6'd0, busy, cmd_sent}, 8'd0);
    chk("abort_last_cmd", last_cmd, 8'h00);
    discard = sb.pop_front();
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      chk("abort_quiet", {5'd0, TX, busy, cmd_sent}, 8'd4);
    end

    chk("sb_drained", 8'(sb.size()), 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
